intxn_phase_arbiter: RTL and testbench

Phase scheduler for the traffic-light intersection. It shares the intersection between competing requesters: east/west car detection, north/south and east/west pedestrian buttons, and emergency preemption. It sequences green, yellow and all-red clearance phases using a millisecond tick derived from the 50 MHz board clock. It drives the 6-bit LED light bus and two walk indicators.

---
 rtl/intxn_pkg.sv | 37 +++
 rtl/intxn_tick_gen.sv | 30 +++
 rtl/intxn_phase_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_intxn_phase_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/intxn_pkg.sv
// Shared state codes and light-bus encodings for the intersection phase arbiter.
package intxn_pkg;

    typedef enum logic [2:0] {
        NS_GRN    = 3'd0,
        NS_YEL    = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GRN    = 3'd3,
        EW_YEL    = 3'd4,
        RED_TO_NS = 3'd5,
        PREEMPT   = 3'd6
    } state_t;

    localparam int LIGHT_NS_RED = 5;
    localparam int LIGHT_NS_YEL = 4;
    localparam int LIGHT_NS_GRN = 3;
    localparam int LIGHT_EW_RED = 2;
    localparam int LIGHT_EW_YEL = 1;
    localparam int LIGHT_EW_GRN = 0;

    localparam logic [5:0] LIGHTS_NS_GRN  = (6'b1 << LIGHT_NS_GRN) | (6'b1 << LIGHT_EW_RED);
    localparam logic [5:0] LIGHTS_NS_YEL  = (6'b1 << LIGHT_NS_YEL) | (6'b1 << LIGHT_EW_RED);
    localparam logic [5:0] LIGHTS_EW_GRN  = (6'b1 << LIGHT_NS_RED) | (6'b1 << LIGHT_EW_GRN);
    localparam logic [5:0] LIGHTS_EW_YEL  = (6'b1 << LIGHT_NS_RED) | (6'b1 << LIGHT_EW_YEL);
    localparam logic [5:0] LIGHTS_ALL_RED = (6'b1 << LIGHT_NS_RED) | (6'b1 << LIGHT_EW_RED);

    function automatic logic [5:0] lights_for(input state_t s);
        case (s)
            NS_GRN:  return LIGHTS_NS_GRN;
            NS_YEL:  return LIGHTS_NS_YEL;
            EW_GRN:  return LIGHTS_EW_GRN;
            EW_YEL:  return LIGHTS_EW_YEL;
            default: return LIGHTS_ALL_RED;
        endcase
    endfunction

endpackage

// File: rtl/intxn_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module intxn_tick_gen #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (count == TERMINAL) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // With a divisor of 1 the count never leaves zero, so tick is constantly high.
    assign tick = (count == TERMINAL);

endmodule

// File: rtl/intxn_phase_arbiter.sv
// Intersection phase scheduler: sequences green/yellow/all-red phases, walk lamps
// and emergency preemption from a millisecond tick.
module intxn_phase_arbiter #(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 1000,
    parameter int MIN_GREEN_MS = 5000,
    parameter int MAX_GREEN_MS = 20000,
    parameter int YELLOW_MS    = 3000,
    parameter int ALL_RED_MS   = 1000,
    parameter int WALK_MS      = 4000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       car_detected,
    input  logic       ped_ns_req,
    input  logic       ped_ew_req,
    input  logic       preempt,
    output logic [5:0] lights_out,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase
);
    import intxn_pkg::*;

    localparam int TW = $clog2(MAX_GREEN_MS + 1);
    localparam int WW = $clog2(WALK_MS + 1);
    localparam logic [TW-1:0] T_MIN  = TW'(MIN_GREEN_MS);
    localparam logic [TW-1:0] T_MAX  = TW'(MAX_GREEN_MS);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_MS);
    localparam logic [TW-1:0] T_RED  = TW'(ALL_RED_MS);
    localparam logic [WW-1:0] T_WALK = WW'(WALK_MS);

    logic          tick;
    state_t        state, state_next;
    logic [TW-1:0] elapsed, elapsed_next, elapsed_inc;
    logic          pend_ew_car, pend_ped_ns, pend_ped_ew;
    logic          pend_ew_car_next, pend_ped_ns_next, pend_ped_ew_next;
    logic          walk_ns_next, walk_ew_next;
    logic [WW-1:0] walk_ns_cnt, walk_ew_cnt, walk_ns_cnt_next, walk_ew_cnt_next;
    logic          preempt_hold, preempt_hold_next;
    logic [5:0]    lights_next;
    logic          ew_demand, preempt_seen;
    logic          start_walk_ns, start_walk_ew, drop_walks;
    logic          clr_ew_car, clr_ped_ns, clr_ped_ew;

    intxn_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Next-state logic; raw request inputs count as demand so a button press
    // after minimum green leaves NS green on the very next edge.
    always_comb begin
        elapsed_inc   = elapsed + TW'(1);
        ew_demand     = pend_ew_car | pend_ped_ew | car_detected | ped_ew_req;
        preempt_seen  = preempt_hold | preempt;
        state_next    = state;
        start_walk_ns = 1'b0;
        start_walk_ew = 1'b0;
        drop_walks    = 1'b0;
        clr_ew_car    = 1'b0;
        clr_ped_ns    = 1'b0;
        clr_ped_ew    = 1'b0;
        case (state)
            NS_GRN: begin
                if (preempt) begin
                    state_next = NS_YEL;
                    drop_walks = 1'b1;
                end else if (elapsed >= T_MIN && !walk_ns && ew_demand) begin
                    state_next = NS_YEL;
                end else if (!ew_demand && !walk_ns && (pend_ped_ns | ped_ns_req)) begin
                    start_walk_ns = 1'b1;
                    clr_ped_ns    = 1'b1;
                end
            end
            NS_YEL: begin
                if (tick && elapsed_inc == T_YEL) state_next = RED_TO_EW;
            end
            RED_TO_EW: begin
                if (tick && elapsed_inc == T_RED) begin
                    if (preempt_seen) begin
                        state_next = PREEMPT;
                    end else begin
                        state_next = EW_GRN;
                        clr_ew_car = 1'b1;
                        if (pend_ped_ew) begin
                            start_walk_ew = 1'b1;
                            clr_ped_ew    = 1'b1;
                        end
                    end
                end
            end
            EW_GRN: begin
                if (preempt) begin
                    state_next = EW_YEL;
                    drop_walks = 1'b1;
                end else if (tick && ((elapsed_inc >= T_MIN && !car_detected) || elapsed_inc == T_MAX)) begin
                    state_next = EW_YEL;
                end
            end
            EW_YEL: begin
                if (tick && elapsed_inc == T_YEL) state_next = RED_TO_NS;
            end
            RED_TO_NS: begin
                if (tick && elapsed_inc == T_RED) begin
                    if (preempt_seen) begin
                        state_next = PREEMPT;
                    end else begin
                        state_next = NS_GRN;
                        if (pend_ped_ns) begin
                            start_walk_ns = 1'b1;
                            clr_ped_ns    = 1'b1;
                        end
                    end
                end
            end
            PREEMPT: begin
                if (!preempt) state_next = RED_TO_NS;
            end
            default: state_next = RED_TO_NS;
        endcase
    end

    // Timer, pending-flag and walk-lamp updates; a clear wins over a same-cycle request.
    always_comb begin
        if (state_next != state) begin
            elapsed_next = '0;
        end else if (tick && elapsed != T_MAX) begin
            elapsed_next = elapsed_inc;
        end else begin
            elapsed_next = elapsed;
        end

        pend_ew_car_next  = clr_ew_car ? 1'b0 : (pend_ew_car | car_detected);
        pend_ped_ns_next  = clr_ped_ns ? 1'b0 : (pend_ped_ns | ped_ns_req);
        pend_ped_ew_next  = clr_ped_ew ? 1'b0 : (pend_ped_ew | ped_ew_req);
        preempt_hold_next = (state_next == PREEMPT) ? 1'b0 : preempt_seen;

        walk_ns_next     = walk_ns;
        walk_ns_cnt_next = walk_ns_cnt;
        walk_ew_next     = walk_ew;
        walk_ew_cnt_next = walk_ew_cnt;
        if (drop_walks) begin
            walk_ns_next = 1'b0;
            walk_ew_next = 1'b0;
        end else begin
            if (start_walk_ns) begin
                walk_ns_next     = 1'b1;
                walk_ns_cnt_next = '0;
            end else if (walk_ns && tick) begin
                if (walk_ns_cnt + WW'(1) == T_WALK) walk_ns_next = 1'b0;
                else                                walk_ns_cnt_next = walk_ns_cnt + WW'(1);
            end
            if (start_walk_ew) begin
                walk_ew_next     = 1'b1;
                walk_ew_cnt_next = '0;
            end else if (walk_ew && tick) begin
                if (walk_ew_cnt + WW'(1) == T_WALK) walk_ew_next = 1'b0;
                else                                walk_ew_cnt_next = walk_ew_cnt + WW'(1);
            end
        end

        lights_next = lights_for(state_next);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RED_TO_NS;
            elapsed      <= '0;
            pend_ew_car  <= 1'b0;
            pend_ped_ns  <= 1'b0;
            pend_ped_ew  <= 1'b0;
            preempt_hold <= 1'b0;
            walk_ns      <= 1'b0;
            walk_ew      <= 1'b0;
            walk_ns_cnt  <= '0;
            walk_ew_cnt  <= '0;
            lights_out   <= LIGHTS_ALL_RED;
        end else begin
            state        <= state_next;
            elapsed      <= elapsed_next;
            pend_ew_car  <= pend_ew_car_next;
            pend_ped_ns  <= pend_ped_ns_next;
            pend_ped_ew  <= pend_ped_ew_next;
            preempt_hold <= preempt_hold_next;
            walk_ns      <= walk_ns_next;
            walk_ew      <= walk_ew_next;
            walk_ns_cnt  <= walk_ns_cnt_next;
            walk_ew_cnt  <= walk_ew_cnt_next;
            lights_out   <= lights_next;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_intxn_phase_arbiter.sv
// Scoreboard bench for intxn_phase_arbiter: every driven cycle queues the expected
// outputs after the next edge, and a monitor pops and compares them.
module tb_intxn_phase_arbiter;

    localparam logic [5:0] L_NSG = 6'b001100;
    localparam logic [5:0] L_NSY = 6'b010100;
    localparam logic [5:0] L_EWG = 6'b100001;
    localparam logic [5:0] L_EWY = 6'b100010;
    localparam logic [5:0] L_RED = 6'b100100;

    // Stimulus bits {reset, car, ped_ns, ped_ew, preempt}
    localparam logic [4:0] IDLE = 5'b00000;
    localparam logic [4:0] RST  = 5'b10000;
    localparam logic [4:0] CAR  = 5'b01000;
    localparam logic [4:0] PNS  = 5'b00100;
    localparam logic [4:0] PEW  = 5'b00010;
    localparam logic [4:0] PRE  = 5'b00001;

    typedef struct {
        logic [5:0] lights;
        logic [2:0] ph;
        logic       wns;
        logic       wew;
        int         scen;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       car_detected = 1'b0;
    logic       ped_ns_req = 1'b0;
    logic       ped_ew_req = 1'b0;
    logic       preempt = 1'b0;
    logic [5:0] lights_out;
    logic       walk_ns;
    logic       walk_ew;
    logic [2:0] phase;

    exp_t exp_q[$];
    int   total_checks = 0;
    int   bad_checks = 0;
    int   scenario = 0;
    int   cycle_no = 0;

    always #5 clock = ~clock;

    intxn_phase_arbiter #(
        .CLK_HZ       (1000),
        .TICK_HZ      (1000),
        .MIN_GREEN_MS (10),
        .MAX_GREEN_MS (20),
        .YELLOW_MS    (3),
        .ALL_RED_MS   (2),
        .WALK_MS      (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .car_detected (car_detected),
        .ped_ns_req   (ped_ns_req),
        .ped_ew_req   (ped_ew_req),
        .preempt      (preempt),
        .lights_out   (lights_out),
        .walk_ns      (walk_ns),
        .walk_ew      (walk_ew),
        .phase        (phase)
    );

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s actual=%b required=%b", tag, actual, expected);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput($sformatf("s%0d.c%0d.lights", e.scen, e.cyc), {2'b00, lights_out}, {2'b00, e.lights});
            checkOutput($sformatf("s%0d.c%0d.phase", e.scen, e.cyc), {5'b0, phase}, {5'b0, e.ph});
            checkOutput($sformatf("s%0d.c%0d.walk_ns", e.scen, e.cyc), {7'b0, walk_ns}, {7'b0, e.wns});
            checkOutput($sformatf("s%0d.c%0d.walk_ew", e.scen, e.cyc), {7'b0, walk_ew}, {7'b0, e.wew});
        end
    end

    task automatic applyStimulus(input logic [4:0] stim, input logic [5:0] lights, input logic [2:0] ph,
                                 input logic wns, input logic wew);
        exp_t e;
        @(negedge clock);
        {reset, car_detected, ped_ns_req, ped_ew_req, preempt} = stim;
        e.lights = lights;
        e.ph     = ph;
        e.wns    = wns;
        e.wew    = wew;
        e.scen   = scenario;
        e.cyc    = cycle_no;
        exp_q.push_back(e);
        cycle_no++;
    endtask

    task automatic runW(input int n, input logic [4:0] stim, input logic [5:0] lights, input logic [2:0] ph,
                        input logic wns, input logic wew);
        for (int i = 0; i < n; i++) applyStimulus(stim, lights, ph, wns, wew);
    endtask

    task automatic run(input int n, input logic [4:0] stim, input logic [5:0] lights, input logic [2:0] ph);
        runW(n, stim, lights, ph, 1'b0, 1'b0);
    endtask

    // Leaves the DUT on the edge that entered NS green (elapsed 0).
    task automatic resetToNs();
        scenario++;
        cycle_no = 0;
        run(3, RST, L_RED, 3'd5);
        run(1, IDLE, L_RED, 3'd5);
        run(1, IDLE, L_NSG, 3'd0);
    endtask

    // From NS green elapsed 0: car pulse, full NS green, yellow, all-red, then EW green entry.
    task automatic toEwGreen();
        run(1, CAR, L_NSG, 3'd0);
        run(9, IDLE, L_NSG, 3'd0);
        run(3, IDLE, L_NSY, 3'd1);
        run(2, IDLE, L_RED, 3'd2);
        run(1, IDLE, L_EWG, 3'd3);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total_checks, bad_checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset, short all-red, then NS green holds with no demand.
        resetToNs();
        run(25, IDLE, L_NSG, 3'd0);

        // Single car pulse runs one full cycle and returns to rest.
        resetToNs();
        run(3, IDLE, L_NSG, 3'd0);
        run(1, CAR, L_NSG, 3'd0);
        run(6, IDLE, L_NSG, 3'd0);
        run(3, IDLE, L_NSY, 3'd1);
        run(2, IDLE, L_RED, 3'd2);
        run(10, IDLE, L_EWG, 3'd3);
        run(3, IDLE, L_EWY, 3'd4);
        run(2, IDLE, L_RED, 3'd5);
        run(15, IDLE, L_NSG, 3'd0);

        // Continuous car demand stretches EW green to the maximum.
        resetToNs();
        run(10, CAR, L_NSG, 3'd0);
        run(3, CAR, L_NSY, 3'd1);
        run(2, CAR, L_RED, 3'd2);
        run(20, CAR, L_EWG, 3'd3);
        run(2, CAR, L_EWY, 3'd4);

        // EW pedestrian after min green, NS rest walk, then preempt from NS green with walk active.
        resetToNs();
        run(12, IDLE, L_NSG, 3'd0);
        run(1, PEW, L_NSY, 3'd1);
        run(2, IDLE, L_NSY, 3'd1);
        run(2, IDLE, L_RED, 3'd2);
        runW(4, IDLE, L_EWG, 3'd3, 1'b0, 1'b1);
        run(6, IDLE, L_EWG, 3'd3);
        run(3, IDLE, L_EWY, 3'd4);
        run(2, IDLE, L_RED, 3'd5);
        run(2, IDLE, L_NSG, 3'd0);
        runW(1, PNS, L_NSG, 3'd0, 1'b1, 1'b0);
        runW(3, IDLE, L_NSG, 3'd0, 1'b1, 1'b0);
        run(5, IDLE, L_NSG, 3'd0);
        runW(1, PNS, L_NSG, 3'd0, 1'b1, 1'b0);
        run(1, PRE, L_NSY, 3'd1);
        run(2, PRE, L_NSY, 3'd1);
        run(2, PRE, L_RED, 3'd2);
        run(4, PRE, L_RED, 3'd6);
        run(2, IDLE, L_RED, 3'd5);
        run(5, IDLE, L_NSG, 3'd0);

        // Preempt during EW green.
        resetToNs();
        toEwGreen();
        run(2, IDLE, L_EWG, 3'd3);
        run(1, PRE, L_EWY, 3'd4);
        run(2, PRE, L_EWY, 3'd4);
        run(2, PRE, L_RED, 3'd5);
        run(5, PRE, L_RED, 3'd6);
        run(2, IDLE, L_RED, 3'd5);
        run(12, IDLE, L_NSG, 3'd0);

        // Reset mid EW yellow discards a pending NS pedestrian request.
        resetToNs();
        toEwGreen();
        run(1, PNS, L_EWG, 3'd3);
        run(8, IDLE, L_EWG, 3'd3);
        run(2, IDLE, L_EWY, 3'd4);
        run(1, RST, L_RED, 3'd5);
        run(1, IDLE, L_RED, 3'd5);
        run(8, IDLE, L_NSG, 3'd0);

        @(posedge clock);
        #3;
        checkOutput("drain", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
